// File: rtl/vend_controller.sv
// Coin-operated vending sequencer: credit accumulation, single dispense, nickel change return.
// Optional inactivity auto-refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int unsigned PRICE    = 4,
  parameter int unsigned CREDIT_W = 5
`ifdef VEND_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 255
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_nickel,
  input  logic                io_dime,
  input  logic                io_quarter,
  input  logic                io_cancel,
  input  logic                io_vend_ack,
  input  logic                io_change_ack,
  output logic                io_vend_req,
  output logic                io_change_req,
  output logic                io_coin_reject,
  output logic                io_busy,
  output logic [CREDIT_W-1:0] io_credit
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_CHANGE
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;
`ifdef VEND_TIMEOUT_EN
  logic [7:0]          idle_cnt_q, idle_cnt_d;
`endif

  logic [3:0]          coin_sum;
  logic                coin_any;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;

  // One extra bit on the sum makes the overflow test a single MSB check.
  always_comb begin
    coin_sum   = {3'b000, io_nickel} + {2'b00, io_dime, 1'b0} + (io_quarter ? 4'd5 : 4'd0);
    coin_any   = |coin_sum;
    credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_sum);
    coin_fits  = ~credit_sum[CREDIT_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      reject_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      reject_q   <= reject_d;
`ifdef VEND_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    reject_d   = 1'b0;
`ifdef VEND_TIMEOUT_EN
    idle_cnt_d = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (coin_any) begin
          if (coin_fits) begin
            credit_d = credit_sum[CREDIT_W-1:0];
            state_d  = ST_COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (coin_any) begin
          if (coin_fits) credit_d = credit_sum[CREDIT_W-1:0];
          else           reject_d = 1'b1;
        end
        // Cancel refunds whatever this cycle's coins brought in, ahead of the price check.
        if (io_cancel && (credit_d != '0)) begin
          state_d = ST_CHANGE;
        end else if (credit_q >= CREDIT_W'(PRICE)) begin
          state_d = ST_DISPENSE;
        end
`ifdef VEND_TIMEOUT_EN
        else if (!coin_any && !io_cancel) begin
          if (idle_cnt_q == 8'(TIMEOUT - 1)) state_d    = ST_CHANGE;
          else                               idle_cnt_d = idle_cnt_q + 8'd1;
        end
`endif
      end
      ST_DISPENSE: begin
        reject_d = coin_any;
        if (io_vend_ack) begin
          if (credit_q > CREDIT_W'(PRICE)) begin
            credit_d = credit_q - CREDIT_W'(PRICE);
            state_d  = ST_CHANGE;
          end else begin
            credit_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        reject_d = coin_any;
        if (io_change_ack) begin
          if (credit_q > CREDIT_W'(1)) begin
            credit_d = credit_q - CREDIT_W'(1);
          end else begin
            credit_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io_vend_req    = (state_q == ST_DISPENSE);
    io_change_req  = (state_q == ST_CHANGE);
    io_busy        = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE);
    io_coin_reject = reject_q;
    io_credit      = credit_q;
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: PRICE=4 instance for the main flows, PRICE=26 instance
// for the credit-overflow boundary. Timeout flow runs only when VEND_TIMEOUT_EN is defined.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_nickel, io_dime, io_quarter, io_cancel, io_vend_ack, io_change_ack;
  logic       vend_req_a, change_req_a, coin_reject_a, busy_a;
  logic [4:0] credit_a;
  logic       vend_req_b, change_req_b, coin_reject_b, busy_b;
  logic [4:0] credit_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE    (4),
    .CREDIT_W (5)
`ifdef VEND_TIMEOUT_EN
    ,
    .TIMEOUT  (10)
`endif
  ) u_dut_a (
    .clk            (clk),
    .reset          (reset),
    .io_nickel      (io_nickel),
    .io_dime        (io_dime),
    .io_quarter     (io_quarter),
    .io_cancel      (io_cancel),
    .io_vend_ack    (io_vend_ack),
    .io_change_ack  (io_change_ack),
    .io_vend_req    (vend_req_a),
    .io_change_req  (change_req_a),
    .io_coin_reject (coin_reject_a),
    .io_busy        (busy_a),
    .io_credit      (credit_a)
  );

  vend_controller #(
    .PRICE    (26),
    .CREDIT_W (5)
  ) u_dut_b (
    .clk            (clk),
    .reset          (reset),
    .io_nickel      (io_nickel),
    .io_dime        (io_dime),
    .io_quarter     (io_quarter),
    .io_cancel      (io_cancel),
    .io_vend_ack    (io_vend_ack),
    .io_change_ack  (io_change_ack),
    .io_vend_req    (vend_req_b),
    .io_change_req  (change_req_b),
    .io_coin_reject (coin_reject_b),
    .io_busy        (busy_b),
    .io_credit      (credit_b)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs (n d q cancel vack cack), then return all to idle.
  task automatic drive(input logic n, input logic d, input logic q,
                       input logic c, input logic va, input logic ca);
    io_nickel = n; io_dime = d; io_quarter = q;
    io_cancel = c; io_vend_ack = va; io_change_ack = ca;
    step();
    io_nickel = 0; io_dime = 0; io_quarter = 0;
    io_cancel = 0; io_vend_ack = 0; io_change_ack = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    io_nickel = 0; io_dime = 0; io_quarter = 0;
    io_cancel = 0; io_vend_ack = 0; io_change_ack = 0;
    do_reset();
    check("rst_credit", credit_a, 0);
    check("rst_vreq", vend_req_a, 0);
    check("rst_creq", change_req_a, 0);
    check("rst_rej", coin_reject_a, 0);
    check("rst_busy", busy_a, 0);

    // 1: four nickels, dispense, exact price
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      check("t1_credit", credit_a, i);
    end
    check("t1_vreq_early", vend_req_a, 0);
    step();
    check("t1_vreq", vend_req_a, 1);
    check("t1_busy", busy_a, 1);
    drive(0, 0, 0, 1, 0, 0);
    check("t1_cancel_ignored", vend_req_a, 1);
    drive(0, 0, 0, 0, 1, 0);
    check("t1_credit_after", credit_a, 0);
    check("t1_vreq_off", vend_req_a, 0);
    check("t1_creq_off", change_req_a, 0);
    check("t1_busy_off", busy_a, 0);

    // 2: quarter, one nickel change
    drive(0, 0, 1, 0, 0, 0);
    check("t2_credit", credit_a, 5);
    step();
    check("t2_vreq", vend_req_a, 1);
    drive(0, 0, 0, 0, 1, 0);
    check("t2_credit_rem", credit_a, 1);
    check("t2_creq", change_req_a, 1);
    check("t2_vreq_off", vend_req_a, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("t2_credit_end", credit_a, 0);
    check("t2_creq_off", change_req_a, 0);

    // 3: simultaneous coins, then four change acks
    drive(1, 1, 1, 0, 0, 0);
    check("t3_credit", credit_a, 8);
    step();
    check("t3_vreq", vend_req_a, 1);
    drive(0, 0, 0, 0, 1, 0);
    check("t3_credit_rem", credit_a, 4);
    for (int i = 3; i >= 0; i--) begin
      check("t3_creq", change_req_a, 1);
      drive(0, 0, 0, 0, 0, 1);
      check("t3_credit_dec", credit_a, i);
    end
    check("t3_creq_off", change_req_a, 0);
    check("t3_busy_off", busy_a, 0);

    // 4: dime then cancel, coin rejected during change
    drive(0, 1, 0, 0, 0, 0);
    check("t4_credit", credit_a, 2);
    drive(0, 0, 0, 1, 0, 0);
    check("t4_creq", change_req_a, 1);
    check("t4_vreq", vend_req_a, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("t4_rej", coin_reject_a, 1);
    check("t4_credit_hold", credit_a, 2);
    step();
    check("t4_rej_pulse", coin_reject_a, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("t4_credit_1", credit_a, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("t4_credit_0", credit_a, 0);
    check("t4_creq_off", change_req_a, 0);

    // cancel beats price; same-cycle coin is refunded too
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    check("cb_credit", credit_a, 4);
    drive(1, 0, 0, 1, 0, 0);
    check("cb_credit_refund", credit_a, 5);
    check("cb_creq", change_req_a, 1);
    check("cb_vreq", vend_req_a, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1);
    check("cb_credit_end", credit_a, 0);
    check("cb_creq_off", change_req_a, 0);

    // acks outside their own state are ignored
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("stray_ack_credit", credit_a, 1);
    check("stray_ack_vreq", vend_req_a, 0);

    // 5: overflow boundary on the PRICE=26 instance, then reset in DISPENSE
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("t5_credit_24", credit_b, 24);
    drive(0, 0, 1, 0, 0, 0);
    check("t5_credit_29", credit_b, 29);
    check("t5_rej_none", coin_reject_b, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("t5_rej", coin_reject_b, 1);
    check("t5_credit_hold", credit_b, 29);
    check("t5_vreq", vend_req_b, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_vreq", vend_req_b, 0);
    check("t5_rst_creq", change_req_b, 0);
    check("t5_rst_rej", coin_reject_b, 0);
    check("t5_rst_busy", busy_b, 0);
    check("t5_rst_credit", credit_b, 0);

`ifdef VEND_TIMEOUT_EN
    // 6: inactivity refund after TIMEOUT=10 idle cycles
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    check("t6_credit", credit_a, 1);
    for (int i = 0; i < 9; i++) step();
    check("t6_creq_early", change_req_a, 0);
    step();
    check("t6_creq", change_req_a, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("t6_credit_end", credit_a, 0);
    check("t6_creq_off", change_req_a, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
